// File: rtl/tile_pkg.sv
// Shared definitions for the tile load scheduler.
//   state_t         : scheduler FSM states
//   DEF_AW / DEF_CW : default address and loop-counter widths
//   OUT_W           : width of the outstanding-read counter
//   TILE_REQS       : requests per tile for the default loop geometry
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_CW = 16;
  localparam int unsigned OUT_W  = 8;

  function automatic int unsigned tile_reqs(input int unsigned n0, input int unsigned n1,
                                            input int unsigned n2, input int unsigned n3);
    return n0 * n1 * n2 * n3;
  endfunction

  localparam int unsigned TILE_REQS = tile_reqs(4, 2, 2, 3);

endpackage

// File: rtl/tile_loop_cnt.sv
// Four-level nested loop counter (word, column, row, channel).
//   clk, rst         : clock, asynchronous active-high reset
//   clr              : return all levels to zero
//   step             : advance the innermost level by one iteration
//   cnt0..cnt3       : current loop indices, cnt0 innermost
//   wrap[k]          : level k and every level inside it sit at their last
//                      index, so the next step wraps level k to zero
//   last             : every level at its last index (final iteration)
module tile_loop_cnt
  import tile_pkg::*;
#(
  parameter int unsigned CW = DEF_CW,
  parameter int unsigned N0 = 4,
  parameter int unsigned N1 = 2,
  parameter int unsigned N2 = 2,
  parameter int unsigned N3 = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3,
  output logic [3:0]    wrap,
  output logic          last
);

  localparam logic [CW-1:0] M0 = CW'(N0 - 1);
  localparam logic [CW-1:0] M1 = CW'(N1 - 1);
  localparam logic [CW-1:0] M2 = CW'(N2 - 1);
  localparam logic [CW-1:0] M3 = CW'(N3 - 1);

  // wrap is cumulative: an outer level only wraps when all inner ones do.
  always_comb begin
    wrap[0] = (cnt0 == M0);
    wrap[1] = wrap[0] && (cnt1 == M1);
    wrap[2] = wrap[1] && (cnt2 == M2);
    wrap[3] = wrap[2] && (cnt3 == M3);
  end

  assign last = wrap[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else if (clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else if (step) begin
      cnt0 <= wrap[0] ? '0 : cnt0 + 1'b1;
      if (wrap[0]) cnt1 <= wrap[1] ? '0 : cnt1 + 1'b1;
      if (wrap[1]) cnt2 <= wrap[2] ? '0 : cnt2 + 1'b1;
      if (wrap[2]) cnt3 <= wrap[3] ? '0 : cnt3 + 1'b1;
    end
  end

endmodule

// File: rtl/tile_load_sched.sv
// Tile load scheduler: walks a 4-level loop issuing memory read requests
// over a valid/ready port, tracks outstanding reads and pulses done once
// every response has returned.
//   clk, rst          : clock, asynchronous active-high reset
//   start, base_addr  : begin a tile at base_addr (accepted only when idle)
//   abort             : stop issuing and drain; flagged on the done pulse
//   req_valid/ready   : read request handshake, req_addr is the address
//   rsp_valid         : one read response returned
//   busy, done        : activity level and one-cycle completion pulse
//   aborted           : qualifies done when the tile was cut short
module tile_load_sched
  import tile_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned CW      = DEF_CW,
  parameter int unsigned N0      = 4,
  parameter int unsigned N1      = 2,
  parameter int unsigned N2      = 2,
  parameter int unsigned N3      = 3,
  parameter int unsigned S1      = 16,
  parameter int unsigned S2      = 64,
  parameter int unsigned S3      = 256,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [AW-1:0] req_addr,
  input  logic          rsp_valid,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUT);

  state_t           state;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] out_next;
  logic             hs;
  logic             rsp_eff;
  logic             start_acc;
  logic [AW-1:0]    rb1, rb2, rb3;
  logic [AW-1:0]    addr_nxt;
  logic [CW-1:0]    cnt0, cnt1, cnt2, cnt3;
  logic [3:0]       wrap;
  logic             last;
  logic             unused_dbg;

  assign start_acc = (state == IDLE) && start;
  assign hs        = req_valid && req_ready;
  // A response with nothing outstanding is stale (e.g. from before a reset).
  assign rsp_eff   = rsp_valid && (outstanding != '0);
  assign out_next  = outstanding + {{(OUT_W-1){1'b0}}, hs} - {{(OUT_W-1){1'b0}}, rsp_eff};

  tile_loop_cnt #(
    .CW (CW),
    .N0 (N0),
    .N1 (N1),
    .N2 (N2),
    .N3 (N3)
  ) u_loop (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .step (hs),
    .cnt0 (cnt0),
    .cnt1 (cnt1),
    .cnt2 (cnt2),
    .cnt3 (cnt3),
    .wrap (wrap),
    .last (last)
  );

  // Loop indices are only needed for debug visibility; the address is
  // derived from the wrap flags alone.
  assign unused_dbg = ^{cnt0, cnt1, cnt2, cnt3, wrap[3]};

  // Next address: the outermost level that advances adds its stride to its
  // own row base; otherwise step to the next word.
  always_comb begin
    if (wrap[2])      addr_nxt = rb3 + AW'(S3);
    else if (wrap[1]) addr_nxt = rb2 + AW'(S2);
    else if (wrap[0]) addr_nxt = rb1 + AW'(S1);
    else              addr_nxt = req_addr + 1'b1;
  end

  // Row bases: an advancing level reloads its own base and every inner one.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      rb1 <= base_addr;
      rb2 <= base_addr;
      rb3 <= base_addr;
    end else if (hs) begin
      if (wrap[2]) rb3 <= addr_nxt;
      if (wrap[1]) rb2 <= addr_nxt;
      if (wrap[0]) rb1 <= addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_valid   <= 1'b0;
      req_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            req_addr  <= base_addr;
            aborted   <= 1'b0;
            busy      <= 1'b1;
            req_valid <= (out_next < MAX_O);
          end
        end
        ISSUE: begin
          if (hs && !last) req_addr <= addr_nxt;
          // A handshake coinciding with abort still counts as issued.
          if (abort || (hs && last)) begin
            state     <= DRAIN;
            req_valid <= 1'b0;
            if (abort) aborted <= 1'b1;
          end else begin
            req_valid <= (out_next < MAX_O);
          end
        end
        DRAIN: begin
          if (abort) aborted <= 1'b1;
          if (out_next == '0) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
